// File: rtl/fsm_voted_seq.sv
// Serial pattern detector with triple-redundant history and fill state.
// Each cycle the three copies are majority-voted, the next value is computed
// from the voted value only, and all copies are reloaded (scrubbed) from it.
// Copy disagreements are counted as upsets. A per-copy injection port lets a
// chosen bit pattern be flipped in one history copy to exercise that path.
module fsm_voted_seq #(
  parameter int             LEN     = 4,
  parameter logic [LEN-1:0] PATTERN = 4'b1011,
  parameter int             CNT_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             din_valid,
  input  logic             clr_err,
  input  logic [1:0]       inj_sel,
  input  logic [LEN-1:0]   inj_mask,
  output logic             detect,
  output logic [CNT_W-1:0] match_cnt,
  output logic             seu_err,
  output logic [CNT_W-1:0] seu_cnt
);

  localparam int             FW       = $clog2(LEN + 1);
  localparam logic [FW-1:0]  FILL_MAX = FW'(LEN);
  localparam logic [FW-1:0]  FILL_THR = FW'(LEN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [2:0][LEN-1:0] h_q;
  logic [2:0][FW-1:0]  f_q;

  logic [LEN-1:0] h_v, h_shift, h_next;
  logic [FW-1:0]  f_v, f_next;
  logic           match, mismatch;

  // Bitwise majority vote of the three copies; shifted candidate history.
  always_comb begin
    h_v     = (h_q[0] & h_q[1]) | (h_q[0] & h_q[2]) | (h_q[1] & h_q[2]);
    f_v     = (f_q[0] & f_q[1]) | (f_q[0] & f_q[2]) | (f_q[1] & f_q[2]);
    h_shift = {h_v[LEN-2:0], din};
  end

  // Next voted history/fill, match decision and copy-disagreement check.
  always_comb begin
    h_next = h_v;
    f_next = f_v;
    if (din_valid) begin
      h_next = h_shift;
      if (f_v < FILL_MAX) f_next = f_v + 1'b1;
    end
    match    = din_valid && (h_shift == PATTERN) && (f_v >= FILL_THR);
    mismatch = (h_q[0] != h_q[1]) || (h_q[0] != h_q[2]) ||
               (f_q[0] != f_q[1]) || (f_q[0] != f_q[2]);
  end

  // Scrub every copy from the voted next value; the selected history copy
  // optionally gets the injection mask applied on top.
  always_ff @(posedge clk) begin
    if (rst) begin
      h_q <= '0;
      f_q <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        h_q[i] <= (inj_sel == 2'(i)) ? (h_next ^ inj_mask) : h_next;
        f_q[i] <= f_next;
      end
    end
  end

  // Registered detect pulse and saturating detection count.
  always_ff @(posedge clk) begin
    if (rst) begin
      detect    <= 1'b0;
      match_cnt <= '0;
    end else begin
      detect <= match;
      if (match && match_cnt != CNT_MAX) match_cnt <= match_cnt + 1'b1;
    end
  end

  // Sticky upset flag and saturating upset count; a disagreement seen in
  // the same cycle as a clear restarts the count at one.
  always_ff @(posedge clk) begin
    if (rst) begin
      seu_err <= 1'b0;
      seu_cnt <= '0;
    end else if (mismatch) begin
      seu_err <= 1'b1;
      if (clr_err)                seu_cnt <= CNT_W'(1);
      else if (seu_cnt != CNT_MAX) seu_cnt <= seu_cnt + 1'b1;
    end else if (clr_err) begin
      seu_err <= 1'b0;
      seu_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_fsm_voted_seq.sv
// Directed bench for fsm_voted_seq (LEN=4, PATTERN=1011, CNT_W=4).
module tb_fsm_voted_seq;

  logic       clk = 1'b0;
  logic       rst, din, din_valid, clr_err;
  logic [1:0] inj_sel;
  logic [3:0] inj_mask;
  logic       detect, seu_err;
  logic [3:0] match_cnt, seu_cnt;

  int total = 0;
  int bad   = 0;

  fsm_voted_seq #(.LEN(4), .PATTERN(4'b1011), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
    .clr_err(clr_err), .inj_sel(inj_sel), .inj_mask(inj_mask),
    .detect(detect), .match_cnt(match_cnt), .seu_err(seu_err),
    .seu_cnt(seu_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic vld;
    logic d;
    logic exp_det;
    int   exp_cnt;
  } vec_t;

  vec_t vecs[21];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic feed(input logic v, input logic d);
    din_valid = v;
    din       = d;
    tick();
  endtask

  initial begin
    // stream 1,0,1,1,0,1,1 (overlap), then 1,0,1,1 with 3-cycle gaps
    vecs[0]  = '{1, 1, 0, 0};
    vecs[1]  = '{1, 0, 0, 0};
    vecs[2]  = '{1, 1, 0, 0};
    vecs[3]  = '{1, 1, 1, 1};
    vecs[4]  = '{1, 0, 0, 1};
    vecs[5]  = '{1, 1, 0, 1};
    vecs[6]  = '{1, 1, 1, 2};
    vecs[7]  = '{1, 1, 0, 2};
    vecs[8]  = '{0, 1, 0, 2};
    vecs[9]  = '{0, 1, 0, 2};
    vecs[10] = '{0, 1, 0, 2};
    vecs[11] = '{1, 0, 0, 2};
    vecs[12] = '{0, 1, 0, 2};
    vecs[13] = '{0, 1, 0, 2};
    vecs[14] = '{0, 1, 0, 2};
    vecs[15] = '{1, 1, 0, 2};
    vecs[16] = '{0, 0, 0, 2};
    vecs[17] = '{0, 0, 0, 2};
    vecs[18] = '{0, 0, 0, 2};
    vecs[19] = '{1, 1, 1, 3};
    vecs[20] = '{0, 1, 0, 3};

    rst = 1'b1; din = 1'b0; din_valid = 1'b0; clr_err = 1'b0;
    inj_sel = 2'd3; inj_mask = 4'd0;
    tick();
    tick();
    chk("rst_detect", detect, 0);
    chk("rst_match_cnt", match_cnt, 0);
    chk("rst_seu_err", seu_err, 0);
    chk("rst_seu_cnt", seu_cnt, 0);
    rst = 1'b0;

    for (int i = 0; i < 21; i++) begin
      feed(vecs[i].vld, vecs[i].d);
      chk($sformatf("vec%0d_detect", i), detect, int'(vecs[i].exp_det));
      chk($sformatf("vec%0d_match_cnt", i), match_cnt, vecs[i].exp_cnt);
    end

    // history is 1011 (last pulse was at vec19); inject into copy 1 while streaming 0,1,1
    inj_sel = 2'd1; inj_mask = 4'b0001;
    feed(1, 0);
    inj_sel = 2'd3; inj_mask = 4'd0;
    chk("inj_no_err_yet", seu_err, 0);
    feed(1, 1);
    chk("inj_seu_err", seu_err, 1);
    chk("inj_seu_cnt", seu_cnt, 1);
    chk("inj_detect_quiet", detect, 0);
    feed(1, 1);
    chk("inj_seu_cnt_hold", seu_cnt, 1);
    chk("inj_seu_err_sticky", seu_err, 1);
    chk("inj_detect", detect, 1);
    chk("inj_match_cnt", match_cnt, 4);

    // overlapping 0,1,1 repeats: 12 more pulses push match_cnt past 15
    for (int i = 0; i < 12; i++) begin
      feed(1, 0);
      feed(1, 1);
      feed(1, 1);
    end
    chk("match_sat_detect", detect, 1);
    chk("match_sat_cnt", match_cnt, 15);
    din_valid = 1'b0;

    // 20 back-to-back single-cycle injections
    for (int i = 0; i < 20; i++) begin
      inj_sel  = 2'(i % 3);
      inj_mask = 4'($urandom_range(1, 15));
      tick();
    end
    inj_sel = 2'd3; inj_mask = 4'd0;
    tick();
    chk("seu_sat_cnt", seu_cnt, 15);
    chk("seu_sat_err", seu_err, 1);
    chk("seu_sat_no_detect", detect, 0);
    tick();
    chk("seu_sat_hold", seu_cnt, 15);

    // clear coinciding with a disagreement restarts count at one
    inj_sel = 2'd0; inj_mask = 4'b1000;
    tick();
    inj_sel = 2'd3; inj_mask = 4'd0; clr_err = 1'b1;
    tick();
    chk("clr_mis_cnt", seu_cnt, 1);
    chk("clr_mis_err", seu_err, 1);
    tick();
    chk("clr_cnt", seu_cnt, 0);
    chk("clr_err", seu_err, 0);
    clr_err = 1'b0;

    // reset mid-stream, asserted together with data, clear and injection
    feed(1, 1);
    feed(1, 0);
    feed(1, 1);
    rst = 1'b1; din_valid = 1'b1; din = 1'b1; clr_err = 1'b1;
    inj_sel = 2'd2; inj_mask = 4'b1111;
    tick();
    rst = 1'b0; din_valid = 1'b0; clr_err = 1'b0;
    inj_sel = 2'd3; inj_mask = 4'd0;
    chk("mid_rst_detect", detect, 0);
    chk("mid_rst_match_cnt", match_cnt, 0);
    chk("mid_rst_seu_err", seu_err, 0);
    chk("mid_rst_seu_cnt", seu_cnt, 0);
    tick();
    chk("mid_rst_no_upset", seu_err, 0);
    feed(1, 1);
    chk("post_rst_single", detect, 0);
    feed(1, 1);
    chk("post_rst_a", detect, 0);
    feed(1, 0);
    chk("post_rst_b", detect, 0);
    feed(1, 1);
    chk("post_rst_c", detect, 0);
    feed(1, 1);
    chk("post_rst_detect", detect, 1);
    chk("post_rst_match_cnt", match_cnt, 1);
    feed(0, 0);
    chk("post_rst_pulse_end", detect, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
